// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the SRAM single-port arbiter.
package sram_arb_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  localparam int unsigned DEF_NREQ  = 2;
  localparam int unsigned DEF_AW    = 9;
  localparam int unsigned DEF_DW    = 8;
  localparam int unsigned DEF_DEPTH = 512;

  // Requester tag width; never zero so a tag field always exists.
  function automatic int unsigned tag_w(input int unsigned nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after rr_ptr, modulo NREQ.
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned TW   = tag_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [TW-1:0]   rr_ptr,
  output logic [NREQ-1:0] gnt_c,
  output logic [TW-1:0]   gnt_idx_c,
  output logic            gnt_any_c
);

  int unsigned    idx;
  logic [TW-1:0]  sel;

  always_comb begin
    gnt_c     = '0;
    gnt_idx_c = '0;
    gnt_any_c = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      // rr_ptr < NREQ and k < NREQ, so one subtraction wraps any NREQ
      idx = 32'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = TW'(idx);
      if (!gnt_any_c && req[sel]) begin
        gnt_c[sel] = 1'b1;
        gnt_idx_c  = sel;
        gnt_any_c  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the RW port of a 512x8 OpenRAM macro between NREQ requesters, with a
// post-reset clear sweep, round-robin grant and a tagged two-stage read return.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned   NREQ     = DEF_NREQ,
  parameter int unsigned   AW       = DEF_AW,
  parameter int unsigned   DW       = DEF_DW,
  parameter int unsigned   DEPTH    = DEF_DEPTH,
  parameter bit            INIT_EN  = 1'b1,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic              init_done,
  output logic              sram_csb0,
  output logic              sram_web0,
  output logic [AW-1:0]     sram_addr0,
  output logic [DW-1:0]     sram_din0,
  input  logic [DW-1:0]     sram_dout0
);

  localparam int unsigned TW = tag_w(NREQ);

  state_e          state_q, state_d;
  logic [AW-1:0]   init_addr_q, init_addr_d;
  logic [TW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   din_q, din_d;
  logic            init_done_q, init_done_d;
  logic            p1_vld_q, p1_vld_d;
  logic [TW-1:0]   p1_id_q, p1_id_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [NREQ-1:0] gnt_c;
  logic [TW-1:0]   gnt_idx_c;
  logic            gnt_any_c;

  rr_arbiter #(
    .NREQ (NREQ),
    .TW   (TW)
  ) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .gnt_c     (gnt_c),
    .gnt_idx_c (gnt_idx_c),
    .gnt_any_c (gnt_any_c)
  );

  // Next state, macro pin mux and response pipeline.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    rr_ptr_d    = rr_ptr_q;
    p1_vld_d    = 1'b0;
    p1_id_d     = p1_id_q;
    req_ready   = '0;
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_addr0  = addr_q;
    sram_din0   = din_q;

    case (state_q)
      ST_INIT: begin
        sram_csb0  = 1'b0;
        sram_web0  = 1'b0;
        sram_addr0 = init_addr_q;
        sram_din0  = INIT_VAL;
        if (init_addr_q == AW'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end else begin
          init_addr_d = init_addr_q + AW'(1);
        end
      end
      default: begin
        if (gnt_any_c) begin
          req_ready  = gnt_c;
          sram_csb0  = 1'b0;
          sram_web0  = ~req_we[gnt_idx_c];
          sram_addr0 = req_addr[gnt_idx_c*AW +: AW];
          sram_din0  = req_wdata[gnt_idx_c*DW +: DW];
          rr_ptr_d   = (gnt_idx_c == TW'(NREQ - 1)) ? '0 : gnt_idx_c + TW'(1);
          p1_vld_d   = ~req_we[gnt_idx_c];
          p1_id_d    = gnt_idx_c;
        end
      end
    endcase

    // Idle cycles re-drive the last address/data, so capture whatever was driven.
    addr_d      = sram_addr0;
    din_d       = sram_din0;
    init_done_d = (state_d == ST_RUN);

    rsp_valid_d = '0;
    if (p1_vld_q) rsp_valid_d[p1_id_q] = 1'b1;
    rsp_rdata_d = p1_vld_q ? sram_dout0 : rsp_rdata_q;

    if (rst) begin
      req_ready  = '0;
      sram_csb0  = 1'b1;
      sram_web0  = 1'b1;
      sram_addr0 = '0;
      sram_din0  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT_EN ? ST_INIT : ST_RUN;
      init_addr_q <= '0;
      rr_ptr_q    <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      init_done_q <= 1'b0;
      p1_vld_q    <= 1'b0;
      p1_id_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      rr_ptr_q    <= rr_ptr_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      init_done_q <= init_done_d;
      p1_vld_q    <= p1_vld_d;
      p1_id_q     <= p1_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: macro model, spec-level reference model, vector table and random traffic.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int NREQ  = 2;
  localparam int AW    = 9;
  localparam int DW    = 8;
  localparam int DEPTH = 512;
  localparam logic [DW-1:0] INIT_VAL = 8'h00;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid, req_we, req_ready, rsp_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [DW-1:0]        rsp_rdata, sram_din0, sram_dout0;
  logic                 init_done, sram_csb0, sram_web0;
  logic [AW-1:0]        sram_addr0;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .DEPTH(DEPTH), .INIT_EN(1'b1), .INIT_VAL(INIT_VAL)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  // Macro: synchronous RW port, read data available the cycle after the access.
  logic [DW-1:0] sram_mem [DEPTH];
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) sram_mem[sram_addr0] <= sram_din0;
      else            sram_dout0 <= sram_mem[sram_addr0];
    end
  end

  // Reference model state
  typedef struct packed {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } rsp_t;

  logic [DW-1:0] m_mem [DEPTH];
  rsp_t          m_q[$];
  int            m_ptr, m_init_addr, cyc;
  bit            m_run, m_done;
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] m_last_din, m_rdata;

  int total = 0;
  int bad   = 0;

  // Samples of the DUT taken in the last step
  logic [NREQ-1:0] s_ready, s_rspv;
  logic [DW-1:0]   s_rdata, s_din;
  logic [AW-1:0]   s_addr;
  logic            s_csb, s_web, s_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, check before posedge, advance model after posedge.
  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ-1:0] we,
                      input logic [NREQ*AW-1:0] a, input logic [NREQ*DW-1:0] d,
                      output int gi);
    logic [NREQ-1:0] e_g, e_rspv;
    logic [AW-1:0]   e_addr;
    logic [DW-1:0]   e_din, e_rdata;
    logic            e_csb, e_web, g_we;
    int              j;
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    #1;
    gi  = -1;
    e_g = '0;
    if (!rst && m_run) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (gi < 0 && ((v >> j) & NREQ'(1)) != '0) gi = j;
      end
    end
    g_we = 1'b0;
    if (gi >= 0) begin
      e_g  = NREQ'(1) << gi;
      g_we = |(we & e_g);
    end
    if (rst) begin
      e_csb = 1'b1; e_web = 1'b1; e_addr = '0; e_din = '0;
    end else if (!m_run) begin
      e_csb = 1'b0; e_web = 1'b0; e_addr = AW'(m_init_addr); e_din = INIT_VAL;
    end else if (gi >= 0) begin
      e_csb = 1'b0; e_web = ~g_we; e_addr = a[gi*AW +: AW]; e_din = d[gi*DW +: DW];
    end else begin
      e_csb = 1'b1; e_web = 1'b1; e_addr = m_last_addr; e_din = m_last_din;
    end
    e_rspv  = '0;
    e_rdata = m_rdata;
    if (m_q.size() > 0 && m_q[0].due == cyc) begin
      e_rspv  = NREQ'(1) << m_q[0].id;
      e_rdata = m_q[0].data;
    end

    s_ready = req_ready; s_rspv = rsp_valid; s_rdata = rsp_rdata; s_done = init_done;
    s_csb = sram_csb0; s_web = sram_web0; s_addr = sram_addr0; s_din = sram_din0;

    check("ready", s_ready, e_g);
    check("pins", {s_csb, s_web, s_addr, s_din}, {e_csb, e_web, e_addr, e_din});
    if (!rst) begin
      check("rsp", {s_rspv, s_rdata}, {e_rspv, e_rdata});
      check("init_done", s_done, m_done);
    end

    @(posedge clk);
    if (rst) begin
      m_run = 1'b0; m_done = 1'b0; m_init_addr = 0; m_ptr = 0;
      m_q.delete(); m_rdata = '0; m_last_addr = '0; m_last_din = '0;
    end else begin
      if (m_q.size() > 0 && m_q[0].due == cyc) begin
        m_rdata = m_q[0].data;
        void'(m_q.pop_front());
      end
      if (!m_run) begin
        m_mem[AW'(m_init_addr)] = INIT_VAL;
        m_last_addr = AW'(m_init_addr);
        m_last_din  = INIT_VAL;
        if (m_init_addr == DEPTH - 1) begin
          m_run = 1'b1; m_done = 1'b1;
        end else begin
          m_init_addr++;
        end
      end else if (gi >= 0) begin
        m_last_addr = e_addr;
        m_last_din  = e_din;
        if (g_we) m_mem[e_addr] = e_din;
        else      m_q.push_back('{cyc + 2, gi, m_mem[e_addr]});
        m_ptr = (gi + 1) % NREQ;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  typedef struct packed {
    logic [1:0] v, we;
    logic [8:0] a0, a1;
    logic [7:0] d0, d1;
    logic [1:0] e_ready, e_rspv;
    logic [7:0] e_rdata;
  } vec_t;

  localparam int NTBL = 19;
  vec_t tbl [NTBL];

  initial begin
    int gi, n_ok;
    logic [NREQ-1:0]    pv, pwe;
    logic [NREQ*AW-1:0] pa;
    logic [NREQ*DW-1:0] pd;

    //            v      we     a0      a1      d0     d1     ready  rspv   rdata
    tbl[0]  = '{2'b01, 2'b01, 9'h1A5, 9'h000, 8'h3C, 8'h00, 2'b01, 2'b00, 8'h00};
    tbl[1]  = '{2'b01, 2'b00, 9'h1A5, 9'h000, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00};
    tbl[2]  = '{2'b00, 2'b00, 9'h000, 9'h000, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00};
    tbl[3]  = '{2'b00, 2'b00, 9'h000, 9'h000, 8'h00, 8'h00, 2'b00, 2'b01, 8'h3C};
    tbl[4]  = '{2'b11, 2'b11, 9'h010, 9'h020, 8'hA1, 8'hB2, 2'b10, 2'b00, 8'h3C};
    tbl[5]  = '{2'b01, 2'b01, 9'h010, 9'h000, 8'hA1, 8'h00, 2'b01, 2'b00, 8'h3C};
    tbl[6]  = '{2'b10, 2'b10, 9'h000, 9'h033, 8'h00, 8'h11, 2'b10, 2'b00, 8'h3C};
    tbl[7]  = '{2'b11, 2'b00, 9'h010, 9'h020, 8'h00, 8'h00, 2'b01, 2'b00, 8'h3C};
    tbl[8]  = '{2'b11, 2'b00, 9'h010, 9'h020, 8'h00, 8'h00, 2'b10, 2'b00, 8'h3C};
    tbl[9]  = '{2'b11, 2'b00, 9'h010, 9'h020, 8'h00, 8'h00, 2'b01, 2'b01, 8'hA1};
    tbl[10] = '{2'b11, 2'b00, 9'h010, 9'h020, 8'h00, 8'h00, 2'b10, 2'b10, 8'hB2};
    tbl[11] = '{2'b00, 2'b00, 9'h000, 9'h000, 8'h00, 8'h00, 2'b00, 2'b01, 8'hA1};
    tbl[12] = '{2'b00, 2'b00, 9'h000, 9'h000, 8'h00, 8'h00, 2'b00, 2'b10, 8'hB2};
    tbl[13] = '{2'b00, 2'b00, 9'h000, 9'h000, 8'h00, 8'h00, 2'b00, 2'b00, 8'hB2};
    tbl[14] = '{2'b10, 2'b00, 9'h000, 9'h033, 8'h00, 8'h00, 2'b10, 2'b00, 8'hB2};
    tbl[15] = '{2'b10, 2'b10, 9'h000, 9'h033, 8'h00, 8'h77, 2'b10, 2'b00, 8'hB2};
    tbl[16] = '{2'b10, 2'b00, 9'h000, 9'h033, 8'h00, 8'h00, 2'b10, 2'b10, 8'h11};
    tbl[17] = '{2'b00, 2'b00, 9'h000, 9'h000, 8'h00, 8'h00, 2'b00, 2'b00, 8'h11};
    tbl[18] = '{2'b00, 2'b00, 9'h000, 9'h000, 8'h00, 8'h00, 2'b00, 2'b10, 8'h77};

    for (int i = 0; i < DEPTH; i++) sram_mem[i] <= DW'($urandom);
    cyc = 0; m_ptr = 0; m_init_addr = 0; m_run = 1'b0; m_done = 1'b0;
    m_rdata = '0; m_last_addr = '0; m_last_din = '0;
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    @(negedge clk);
    step('0, '0, '0, '0, gi);
    step('0, '0, '0, '0, gi);
    rst = 1'b0;

    // Clear sweep with both requesters already waiting
    n_ok = 0;
    for (int i = 0; i < DEPTH; i++) begin
      step(2'b11, 2'b00, {9'h020, 9'h010}, '0, gi);
      if (s_csb == 1'b0 && s_web == 1'b0 && s_addr == AW'(i) && s_din == INIT_VAL &&
          s_ready == '0 && s_done == 1'b0) n_ok++;
    end
    check("init_sweep_writes", n_ok, DEPTH);
    step(2'b11, 2'b00, {9'h020, 9'h010}, '0, gi);
    check("init_done_rise", s_done, 1);
    check("first_grant", s_ready, 2'b01);
    step(2'b10, 2'b00, {9'h020, 9'h010}, '0, gi);
    check("second_grant", s_ready, 2'b10);
    for (int i = 0; i < 3; i++) step('0, '0, '0, '0, gi);

    // Write/read, alternating reads, read-before-write ordering
    for (int r = 0; r < NTBL; r++) begin
      step(tbl[r].v, tbl[r].we, {tbl[r].a1, tbl[r].a0}, {tbl[r].d1, tbl[r].d0}, gi);
      check($sformatf("tbl%0d_ready", r), s_ready, tbl[r].e_ready);
      check($sformatf("tbl%0d_rsp", r), {s_rspv, s_rdata}, {tbl[r].e_rspv, tbl[r].e_rdata});
    end

    // req1 back-to-back reads of 0..7 after distinct preloads
    for (int i = 0; i < 8; i++)
      step(2'b10, 2'b10, {AW'(i), AW'(0)}, {DW'(8'h50 + i), DW'(0)}, gi);
    for (int k = 0; k < 10; k++) begin
      if (k < 8) step(2'b10, 2'b00, {AW'(k), AW'(0)}, '0, gi);
      else       step('0, '0, '0, '0, gi);
      if (k < 8)  check("b2b_ready", s_ready, 2'b10);
      if (k >= 2) check("b2b_rsp", {s_rspv, s_rdata}, {2'b10, DW'(8'h50 + k - 2)});
    end

    // Reset right after an accepted read
    step(2'b01, 2'b00, {AW'(0), 9'h005}, '0, gi);
    check("rd5_accept", s_ready, 2'b01);
    rst = 1'b1;
    step('0, '0, '0, '0, gi);
    check("csb_in_reset", s_csb, 1);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step('0, '0, '0, '0, gi);
      check("no_rsp_after_reset", s_rspv, 2'b00);
      if (k == 0) begin
        check("sweep_restart", {s_csb, s_web, s_addr}, {1'b0, 1'b0, AW'(0)});
        check("init_done_low", s_done, 0);
      end
    end
    for (int k = 4; k < DEPTH; k++) step('0, '0, '0, '0, gi);

    // Random traffic on a small address window to force hazards
    pv = '0; pwe = '0; pa = '0; pd = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (((pv >> i) & NREQ'(1)) == '0 && $urandom_range(0, 3) != 0) begin
          pv = pv | (NREQ'(1) << i);
          if ($urandom_range(0, 1) == 1) pwe = pwe | (NREQ'(1) << i);
          else                           pwe = pwe & ~(NREQ'(1) << i);
          pa[i*AW +: AW] = AW'($urandom_range(0, 15));
          pd[i*DW +: DW] = DW'($urandom);
        end
      end
      step(pv, pwe, pa, pd, gi);
      if (gi >= 0) pv = pv & ~(NREQ'(1) << gi);
    end
    for (int i = 0; i < 4; i++) step('0, '0, '0, '0, gi);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
